decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 100 ++++++++++
 tb/tb_decode_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, 32x32 register file with write-back bypass, immediate/branch decode.
// One edge from fetch to decode outputs; out_stall holds PC and IF/ID on a load-use hazard.
module decode_stage (
   input  logic        inp_clk,
   input  logic        inp_rst_n,
   input  logic [31:0] inp_instr,
   input  logic [31:0] inp_pc_plus4,
   input  logic        inp_if_valid,
   input  logic        inp_flush,
   input  logic        inp_wb_en,
   input  logic [4:0]  inp_wb_addr,
   input  logic [31:0] inp_wb_data,
   input  logic        inp_ex_memread,
   input  logic [4:0]  inp_ex_rt,
   output logic        out_stall,
   output logic        out_valid,
   output logic [31:0] out_pc_plus4,
   output logic [31:0] out_rs_data,
   output logic [31:0] out_rt_data,
   output logic [31:0] out_imm,
   output logic [31:0] out_branch_target,
   output logic [5:0]  out_opcode,
   output logic [5:0]  out_funct,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_rd
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] rf_q [32];
   logic [31:0] simm;
   logic        wb_write;

   assign wb_write = inp_wb_en && (inp_wb_addr != 5'd0);

   // Flush wins over stall so a held instruction is discarded on a taken branch.
   always_comb begin
      valid_d = inp_if_valid;
      instr_d = inp_instr;
      pc4_d   = inp_pc_plus4;
      if (inp_flush) begin
         valid_d = 1'b0;
         instr_d = 32'd0;
         pc4_d   = pc4_q;
      end else if (out_stall) begin
         valid_d = valid_q;
         instr_d = instr_q;
         pc4_d   = pc4_q;
      end
   end

   always_ff @(posedge inp_clk) begin
      if (!inp_rst_n) begin
         valid_q <= 1'b0;
         instr_q <= 32'd0;
         pc4_q   <= 32'd0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   always_ff @(posedge inp_clk) begin
      if (!inp_rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (wb_write) begin
         rf_q[inp_wb_addr] <= inp_wb_data;
      end
   end

   assign out_opcode   = instr_q[31:26];
   assign out_rs       = instr_q[25:21];
   assign out_rt       = instr_q[20:16];
   assign out_rd       = instr_q[15:11];
   assign out_funct    = instr_q[5:0];
   assign out_pc_plus4 = pc4_q;

   assign simm              = {{16{instr_q[15]}}, instr_q[15:0]};
   assign out_imm           = (out_opcode == 6'h0C || out_opcode == 6'h0D)
                              ? {16'd0, instr_q[15:0]} : simm;
   assign out_branch_target = pc4_q + {simm[29:0], 2'b00};

   // Same-cycle write-back is forwarded so the reader never sees the stale value.
   always_comb begin
      out_rs_data = rf_q[out_rs];
      out_rt_data = rf_q[out_rt];
      if (wb_write && inp_wb_addr == out_rs) out_rs_data = inp_wb_data;
      if (wb_write && inp_wb_addr == out_rt) out_rt_data = inp_wb_data;
      if (out_rs == 5'd0) out_rs_data = 32'd0;
      if (out_rt == 5'd0) out_rt_data = 32'd0;
   end

   assign out_stall = valid_q && inp_ex_memread && (inp_ex_rt != 5'd0)
                      && (inp_ex_rt == out_rs || inp_ex_rt == out_rt);
   assign out_valid = valid_q && !out_stall;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, write-back/bypass, load-use stall, flush, reset.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, if_valid, flush, wb_en, ex_memread;
   logic [31:0] instr, pc4, wb_data;
   logic [4:0]  wb_addr, ex_rt;
   logic        stall, valid;
   logic [31:0] o_pc4, rs_data, rt_data, imm, bt;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .inp_clk(clk), .inp_rst_n(rst_n), .inp_instr(instr), .inp_pc_plus4(pc4),
      .inp_if_valid(if_valid), .inp_flush(flush), .inp_wb_en(wb_en),
      .inp_wb_addr(wb_addr), .inp_wb_data(wb_data), .inp_ex_memread(ex_memread),
      .inp_ex_rt(ex_rt), .out_stall(stall), .out_valid(valid), .out_pc_plus4(o_pc4),
      .out_rs_data(rs_data), .out_rt_data(rt_data), .out_imm(imm),
      .out_branch_target(bt), .out_opcode(opcode), .out_funct(funct),
      .out_rs(rs), .out_rt(rt), .out_rd(rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; if_valid = 0; flush = 0; wb_en = 0; ex_memread = 0;
      instr = 32'h0; pc4 = 32'h0; wb_data = 32'h0; wb_addr = 5'd0; ex_rt = 5'd0;
      tick(); tick();
      rst_n = 1;
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_pc4", o_pc4, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_bt", bt, 32'd0);
      chk("rst_rs_data", rs_data, 32'd0);
      chk("rst_rt_data", rt_data, 32'd0);
      chk("rst_fields", {opcode, funct, rs, rt, rd}, 32'd0);

      // Capture/decode of addi with negative immediate
      instr = 32'h2128FFFC; pc4 = 32'h100; if_valid = 1;
      tick();
      chk("cap_rs", {27'd0, rs}, 32'd9);
      chk("cap_rt", {27'd0, rt}, 32'd8);
      chk("cap_rd", {27'd0, rd}, 32'd31);
      chk("cap_opcode", {26'd0, opcode}, 32'h08);
      chk("cap_funct", {26'd0, funct}, 32'h3C);
      chk("cap_imm", imm, 32'hFFFFFFFC);
      chk("cap_bt", bt, 32'h000000F0);
      chk("cap_valid", {31'd0, valid}, 32'd1);
      chk("cap_pc4", o_pc4, 32'h100);

      // ori: zero-extended immediate, branch target still sign-extended
      instr = 32'h3508FFFF; pc4 = 32'h200;
      tick();
      chk("zext_imm", imm, 32'h0000FFFF);
      chk("zext_bt", bt, 32'h000001FC);

      // Write-back bypass and later read of r5
      instr = 32'h00A63820; pc4 = 32'h204;
      tick();
      wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      #1;
      chk("wb_bypass", rs_data, 32'hDEADBEEF);
      chk("wb_rt_untouched", rt_data, 32'd0);
      tick();
      wb_en = 0;
      #1;
      chk("wb_stored", rs_data, 32'hDEADBEEF);

      // r0 stays zero
      instr = 32'h00000020;
      tick();
      wb_en = 1; wb_addr = 5'd0; wb_data = 32'h1234;
      #1;
      chk("r0_bypass", rs_data, 32'd0);
      tick();
      wb_en = 0;
      #1;
      chk("r0_stored", rs_data, 32'd0);

      // Load-use hazard on rt
      instr = 32'h2128FFFC; pc4 = 32'h100;
      tick();
      ex_memread = 1; ex_rt = 5'd8;
      #1;
      chk("lu_stall", {31'd0, stall}, 32'd1);
      chk("lu_valid", {31'd0, valid}, 32'd0);
      instr = 32'h00A63820; pc4 = 32'h300;
      tick();
      chk("lu_hold_stall", {31'd0, stall}, 32'd1);
      chk("lu_hold_funct", {26'd0, funct}, 32'h3C);
      chk("lu_hold_pc4", o_pc4, 32'h100);
      ex_memread = 0;
      #1;
      chk("lu_release_stall", {31'd0, stall}, 32'd0);
      chk("lu_release_valid", {31'd0, valid}, 32'd1);
      chk("lu_release_rt", {27'd0, rt}, 32'd8);
      ex_memread = 1; ex_rt = 5'd0;
      #1;
      chk("lu_r0_nostall", {31'd0, stall}, 32'd0);

      // Flush while stalled on rs
      ex_rt = 5'd9;
      #1;
      chk("fl_pre_stall", {31'd0, stall}, 32'd1);
      flush = 1;
      tick();
      flush = 0;
      #1;
      chk("fl_valid", {31'd0, valid}, 32'd0);
      chk("fl_stall", {31'd0, stall}, 32'd0);
      chk("fl_opcode", {26'd0, opcode}, 32'd0);
      chk("fl_imm", imm, 32'd0);
      ex_memread = 0; ex_rt = 5'd0;

      // Reset mid-operation drops register contents and a concurrent write
      instr = 32'h00640000; pc4 = 32'h400;
      wb_en = 1; wb_addr = 5'd3; wb_data = 32'd7;
      tick();
      wb_en = 0;
      #1;
      chk("pre_rst_r3", rs_data, 32'd7);
      chk("pre_rst_valid", {31'd0, valid}, 32'd1);
      rst_n = 0; wb_en = 1; wb_addr = 5'd4; wb_data = 32'h55;
      tick();
      rst_n = 1; wb_en = 0;
      #1;
      chk("post_rst_valid", {31'd0, valid}, 32'd0);
      chk("post_rst_pc4", o_pc4, 32'd0);
      tick();
      chk("post_rst_r3", rs_data, 32'd0);
      chk("post_rst_r4", rt_data, 32'd0);
      chk("post_rst_recapture", {31'd0, valid}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
